// File: rtl/div_sched.sv
// Two-requester scheduler sharing one 32/16 divider; one transaction in flight, round-robin grant.
// Define DIV_SCHED_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).

module div (
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic [16:0] quotient,
  output logic [15:0] remainder
);
  always_comb begin
    quotient  = '0;
    remainder = '0;
    if (divisor != 16'd0) begin
      quotient  = 17'(dividend / {16'd0, divisor});
      remainder = 16'(dividend % {16'd0, divisor});
    end
  end
endmodule

module div_sched #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_dividend,
  input  logic [31:0] req1_dividend,
  input  logic [15:0] req0_divisor,
  input  logic [15:0] req1_divisor,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [16:0] resp_quotient,
  output logic [15:0] resp_remainder,
  output logic        resp_dbz,
  output logic        resp_ovf
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t      state, nstate;
  logic [3:0]  cnt;
  logic        last_gnt;
  logic        gnt;
  logic        acc;
  logic [31:0] sel_a;
  logic [15:0] sel_b;
  logic [31:0] op_a;
  logic [15:0] op_b;
  logic        op_id;

  logic [31:0] div_a;
  logic [15:0] div_b;
  logic [16:0] div_q;
  logic [15:0] div_r;
  logic [16:0] res_q;
  logic [15:0] res_r;
  logic        res_dbz, res_ovf;

  // Both valid: the requester not granted last time wins.
  always_comb begin
    gnt = 1'b0;
    if (req_valid == 2'b11) gnt = ~last_gnt;
    else if (req_valid[1])  gnt = 1'b1;
    req_ready = 2'b00;
    if (state == IDLE && !rst && (|req_valid))
      req_ready = gnt ? 2'b10 : 2'b01;
  end

  assign acc   = |(req_valid & req_ready);
  assign sel_a = gnt ? req1_dividend : req0_dividend;
  assign sel_b = gnt ? req1_divisor  : req0_divisor;

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (acc) nstate = WAIT;
      WAIT:    if (cnt == 4'd0) nstate = DONE;
      DONE:    if (resp_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  div u_div (
    .dividend  (div_a),
    .divisor   (div_b),
    .quotient  (div_q),
    .remainder (div_r)
  );

`ifdef DIV_SCHED_SIGNED_EN
  logic a_neg, b_neg;
  assign a_neg = op_a[31];
  assign b_neg = op_b[15];
  assign div_a = a_neg ? -op_a : op_a;
  assign div_b = b_neg ? -op_b : op_b;

  always_comb begin
    res_dbz = (op_b == 16'd0);
    // magnitude quotient >= 2^16 cannot be represented as a signed 17-bit value
    res_ovf = !res_dbz && (div_a[31:16] >= div_b);
    res_q   = (a_neg ^ b_neg) ? -div_q : div_q;
    res_r   = a_neg ? -div_r : div_r;
    if (res_dbz) begin
      res_q = '1;
      res_r = op_a[15:0];
    end else if (res_ovf) begin
      res_q = '1;
    end
  end
`else
  assign div_a = op_a;
  assign div_b = op_b;

  always_comb begin
    res_dbz = (op_b == 16'd0);
    res_ovf = !res_dbz && ({1'b0, op_a[31:17]} >= op_b);
    res_q   = div_q;
    res_r   = div_r;
    if (res_dbz) begin
      res_q = '1;
      res_r = op_a[15:0];
    end else if (res_ovf) begin
      res_q = '1;
    end
  end
`endif

  assign resp_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      last_gnt       <= 1'b1;
      op_a           <= '0;
      op_b           <= '0;
      op_id          <= 1'b0;
      resp_id        <= 1'b0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_dbz       <= 1'b0;
      resp_ovf       <= 1'b0;
    end else begin
      state <= nstate;
      if (state == IDLE && acc) begin
        op_a     <= sel_a;
        op_b     <= sel_b;
        op_id    <= gnt;
        last_gnt <= gnt;
        // divide-by-zero needs no settle time: one WAIT cycle only
        cnt      <= (sel_b == 16'd0) ? 4'd0 : CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == WAIT && cnt == 4'd0) begin
        resp_id        <= op_id;
        resp_quotient  <= res_q;
        resp_remainder <= res_r;
        resp_dbz       <= res_dbz;
        resp_ovf       <= res_ovf;
      end
    end
  end
endmodule
